// File: rtl/commit_trace_sink.sv
// Commit-bus trace sink: buffers in-order retirements in a FIFO, counts commits, checks ROB tag order.
// Optional COMMIT_TRACE_WRONLY_EN: only register-writing commits are pushed into the trace FIFO.
module commit_trace_sink #(
    parameter int WIDTH = 31,
    parameter int REG   = 4,
    parameter int ROB   = 2,
    parameter int PTR   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             validCommit,
    input  logic             rgWr,
    input  logic [REG:0]     regDest,
    input  logic [WIDTH:0]   result,
    input  logic [ROB:0]     robCommit,
    input  logic             traceReady,
    output logic             traceValid,
    output logic             traceWr,
    output logic [REG:0]     traceReg,
    output logic [WIDTH:0]   traceData,
    output logic [ROB:0]     traceRob,
    output logic [31:0]      commitCount,
    output logic             fifoFull,
    output logic             fifoEmpty,
    output logic             overflow,
    output logic             orderError
);

    localparam int DEPTH = 2 ** (PTR + 1);
    localparam int EW    = 1 + (REG + 1) + (WIDTH + 1) + (ROB + 1);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t          state;
    logic [ROB:0]    exp_tag;
    logic [PTR+1:0]  wr_ptr;
    logic [PTR+1:0]  rd_ptr;
    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   head;

    logic accept;
    logic push_req;
    logic push;
    logic pop;

    always_comb begin
        accept = 1'b0;
        if (validCommit) begin
            case (state)
                SYNC:    accept = 1'b1;
                TRACK:   accept = (robCommit == exp_tag);
                default: accept = 1'b0;
            endcase
        end
    end

`ifdef COMMIT_TRACE_WRONLY_EN
    assign push_req = accept && rgWr;
`else
    assign push_req = accept;
`endif

    // Wrap bit differs and index matches -> every slot holds an entry.
    assign fifoEmpty  = (wr_ptr == rd_ptr);
    assign fifoFull   = (wr_ptr[PTR+1] != rd_ptr[PTR+1]) && (wr_ptr[PTR:0] == rd_ptr[PTR:0]);
    assign traceValid = !fifoEmpty;
    assign pop        = traceValid && traceReady;
    assign push       = push_req && (!fifoFull || pop);

    assign head = mem[rd_ptr[PTR:0]];
    assign {traceWr, traceReg, traceData, traceRob} = head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SYNC;
            exp_tag     <= '0;
            orderError  <= 1'b0;
            commitCount <= '0;
        end else begin
            if (validCommit)
                commitCount <= commitCount + 32'd1;
            case (state)
                SYNC: begin
                    if (validCommit) begin
                        exp_tag <= robCommit + 1'b1;
                        state   <= TRACK;
                    end
                end
                TRACK: begin
                    if (validCommit) begin
                        // Tag still advances when the push is dropped for lack of space.
                        if (robCommit == exp_tag) begin
                            exp_tag <= exp_tag + 1'b1;
                        end else begin
                            orderError <= 1'b1;
                            state      <= HALT;
                        end
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[PTR:0]] <= {rgWr, regDest, result, robCommit};
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_req && !push)
                overflow <= 1'b1;
        end
    end

endmodule
